axis_circular_reader: RTL and testbench
=======================================

AXIS_CIRCULAR_READER -- requirements
Module: axis_circular_reader

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning the stream and BRAM data width in bits.
REQ-002 The block SHALL have parameter BRAM_ADDR_WIDTH, default 16, meaning the BRAM word address width; the circular buffer depth is 2^BRAM_ADDR_WIDTH words.
REQ-003 The block SHALL have parameter CONTINUOUS, default "FALSE", meaning re-arm automatically after each completed readout when "TRUE".
REQ-004 The block SHALL have port aclk, input, 1 bit: clock.
REQ-005 The block SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port cfg_start, input, BRAM_ADDR_WIDTH bits: first word address, i.e. the capture-side trigger position.
REQ-007 The block SHALL have port cfg_length, input, BRAM_ADDR_WIDTH+1 bits: number of beats to read, 0..2^BRAM_ADDR_WIDTH.
REQ-008 The block SHALL have port start, input, 1 bit: readout request, sampled on each rising aclk edge.
REQ-009 The block SHALL have port sts_busy, output, 1 bit: high while a readout is active.
REQ-010 The block SHALL have port sts_count, output, BRAM_ADDR_WIDTH+1 bits: beats accepted downstream in the current or last readout.
REQ-011 The block SHALL have the following BRAM port A signals: bram_porta_clk, output, 1 bit; bram_porta_rst, output, 1 bit; bram_porta_addr, output, BRAM_ADDR_WIDTH bits; bram_porta_rddata, input, AXIS_TDATA_WIDTH bits.
REQ-012 The block SHALL have the following master stream signals: m_axis_tready, input, 1 bit; m_axis_tdata, output, AXIS_TDATA_WIDTH bits; m_axis_tvalid, output, 1 bit; m_axis_tlast, output, 1 bit.

Function
REQ-013 bram_porta_clk SHALL equal aclk, and bram_porta_rst SHALL equal ~aresetn.
REQ-014 BRAM read latency SHALL be 1 cycle: data for the address registered at edge n is valid on bram_porta_rddata after edge n+1.
REQ-015 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-016 In IDLE with start=1 and cfg_length!=0, the block SHALL latch cfg_start and cfg_length, clear sts_count, enter READ and assert sts_busy on the next cycle.
REQ-017 In IDLE, start with cfg_length=0 SHALL be ignored.
REQ-018 start SHALL be ignored in READ and DRAIN, and cfg_* changes during a readout SHALL have no effect.
REQ-019 The read address SHALL be (latched start + issue offset) mod 2^BRAM_ADDR_WIDTH, wrapping naturally from all-ones to 0 with no gap.
REQ-020 A read SHALL be issued only when (buffered beats + reads in flight) < 2, giving a 2-entry output buffer with no data loss under any tready pattern.
REQ-021 With tready held high, the output SHALL sustain 1 beat/cycle.
REQ-022 The first tvalid SHALL occur 2 cycles after the cycle in which start is sampled.
REQ-023 After cfg_length reads are issued, the FSM SHALL enter DRAIN; issuing SHALL stop, and the block SHALL wait for the buffer to empty.
REQ-024 Beats SHALL be delivered in address order, with tdata unchanged while tvalid=1 and tready=0.
REQ-025 m_axis_tlast SHALL be 1 only on the beat numbered cfg_length.
REQ-026 sts_count SHALL increment on each tvalid&tready handshake.
REQ-027 cfg_length = 2^BRAM_ADDR_WIDTH SHALL read the whole buffer exactly once, with the last address equal to start-1.
REQ-028 On DRAIN completion (final handshake), with CONTINUOUS="FALSE" the block SHALL go to IDLE and drop sts_busy the next cycle.
REQ-029 On DRAIN completion, with CONTINUOUS="TRUE" the block SHALL re-latch cfg_* and re-enter READ immediately if cfg_length!=0, otherwise go to IDLE.

Reset
REQ-030 While aresetn=0, state SHALL be IDLE; m_axis_tvalid, m_axis_tlast, sts_busy, sts_count, bram_porta_addr and the buffer occupancy SHALL be 0.
REQ-031 Reset asserted mid-readout SHALL abort it; buffered and in-flight data SHALL be discarded, with no further beats after reset.

Structure
REQ-032 FSM state encodings and the buffer depth constant (2) SHALL reside in a shared package or include common to the circular-capture cores.
REQ-033 The output buffer SHALL be one sub-module, axis_skid_buffer2 (2-entry AXIS FIFO exposing an occupancy count).

Verification
REQ-034 Verification SHALL cover: BRAM_ADDR_WIDTH=4, BRAM word i = i, cfg_start=12, cfg_length=8, tready=1 -> tdata 12,13,14,15,0,1,2,3 on consecutive cycles, tlast on 3, first tvalid 2 cycles after start.
REQ-035 Verification SHALL cover: cfg_start=5, cfg_length=16 -> tdata 5..15,0..4, tlast on 4, sts_count=16, sts_busy falls 1 cycle after the last handshake.
REQ-036 Verification SHALL cover: random 50% tready with cfg_length=10 -> exactly 10 beats in order, no duplicates or drops, tdata stable while stalled.
REQ-037 Verification SHALL cover: start pulsed again mid-readout and cfg_start changed -> the sequence is unaffected; start with cfg_length=0 -> sts_busy stays 0.
REQ-038 Verification SHALL cover: aresetn=0 for 1 cycle after beat 3 of 8 -> tvalid=0 and sts_count=0 the next cycle, and no further beats.
REQ-039 Verification SHALL cover: CONTINUOUS="TRUE", cfg_length=4 -> back-to-back packets of 4 with tlast every 4th beat, sts_busy held high.

Source files
------------

// File: rtl/axis_circular_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_circular_reader_pkg
// Description : Shared types and constants for the circular-capture cores:
//               readout FSM encoding and output buffer sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_circular_reader_pkg;

    // Readout controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

    // Output buffer depth and the width of its occupancy count
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // Default stream width for the stream interface
    localparam int unsigned AXIS_DEFAULT_WIDTH = 32;

    // A new BRAM read may be launched only while the beats already owned by
    // the reader (buffered plus in flight, net of this cycle's handshake)
    // leave room in the buffer for it.
    function automatic logic may_issue(input logic [SKID_CNT_W:0] outstanding);
        return outstanding < (SKID_CNT_W + 1)'(SKID_DEPTH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_circular_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_circular_reader_if
// Description : AXI4-Stream master bundle (tdata/tvalid/tready/tlast) with
//               master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_circular_reader_if
    import axis_circular_reader_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DEFAULT_WIDTH
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

`default_nettype wire

// File: rtl/axis_circular_reader_skid_buffer2.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_buffer2
// Description : Two-entry stream FIFO with a same-cycle bypass when empty.
//               The writer is credit-controlled through count_o, so there is
//               no input ready; incoming data is either handed straight to
//               the output (empty and ready) or stored.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buffer2
    import axis_circular_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  aclk,
    input  wire logic                  aresetn,
    input  wire logic                  s_valid_i,
    input  wire logic [DATA_WIDTH-1:0] s_data_i,
    input  wire logic                  m_ready_i,
    output logic                       m_valid_o,
    output logic      [DATA_WIDTH-1:0] m_data_o,
    output logic      [SKID_CNT_W-1:0] count_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [SKID_CNT_W-1:0] occ_q;
    logic [SKID_CNT_W-1:0] occ_d;

    logic w_empty;
    logic w_pop;
    logic w_bypass;
    logic w_store;
    logic w_drop_head;

    assign w_empty   = (occ_q == '0);
    assign m_valid_o = !w_empty || s_valid_i;
    assign m_data_o  = w_empty ? s_data_i : mem_q[rd_ptr_q];
    assign count_o   = occ_q;

    assign w_pop       = m_valid_o && m_ready_i;
    // Input goes straight out only when nothing older is waiting
    assign w_bypass    = w_empty && m_ready_i;
    assign w_store     = s_valid_i && !w_bypass;
    assign w_drop_head = w_pop && !w_empty;

    // Next occupancy: one in for a store, one out for a pop of a stored entry
    always_comb begin
        occ_d = occ_q;
        if (w_store && !w_drop_head) begin
            occ_d = occ_q + 1'b1;
        end else if (!w_store && w_drop_head) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Occupancy and ring pointers; reset empties the buffer
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            occ_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            if (w_store) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_drop_head) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Data storage; contents are don't-care while the count says empty
    always_ff @(posedge aclk) begin
        if (w_store) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_circular_reader.sv
`default_nettype none
// ============================================================================
// Module      : axis_circular_reader
// Description : Reads cfg_length words out of a circular BRAM buffer starting
//               at cfg_start (wrapping at the top) and streams them on an
//               AXI4-Stream master with tlast on the final beat. Optional
//               continuous re-arming after each readout.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_circular_reader
    import axis_circular_reader_pkg::*;
#(
    parameter int    AXIS_TDATA_WIDTH = 32,
    parameter int    BRAM_ADDR_WIDTH  = 16,
    parameter string CONTINUOUS       = "FALSE"
) (
    input  wire logic                        aclk,
    input  wire logic                        aresetn,

    input  wire logic [BRAM_ADDR_WIDTH-1:0]  cfg_start,
    input  wire logic [BRAM_ADDR_WIDTH:0]    cfg_length,
    input  wire logic                        start,

    output logic                             sts_busy,
    output logic      [BRAM_ADDR_WIDTH:0]    sts_count,

    output logic                             bram_porta_clk,
    output logic                             bram_porta_rst,
    output logic      [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  wire logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,

    axis_circular_reader_if.master           m_axis
);

    localparam bit c_continuous = (CONTINUOUS == "TRUE");
    localparam logic [BRAM_ADDR_WIDTH:0] c_len_one = (BRAM_ADDR_WIDTH + 1)'(1);

    reader_state_t               state_q;
    logic                        busy_q;
    logic [BRAM_ADDR_WIDTH-1:0]  addr_q;
    logic [BRAM_ADDR_WIDTH:0]    len_q;
    logic [BRAM_ADDR_WIDTH:0]    issued_q;
    logic [BRAM_ADDR_WIDTH:0]    count_q;
    logic                        req_q;       // read address presented this cycle
    logic                        rd_valid_q;  // BRAM data for it is on rddata

    logic                        w_valid;
    logic [AXIS_TDATA_WIDTH-1:0] w_data;
    logic [SKID_CNT_W-1:0]       w_occ;
    logic                        w_pop;
    logic                        w_last_beat;
    logic                        w_done;
    logic                        w_launch;
    logic [SKID_CNT_W:0]         w_outstanding;
    logic                        w_issue_ok;

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr_q;

    assign sts_busy  = busy_q;
    assign sts_count = count_q;

    axis_skid_buffer2 #(
        .DATA_WIDTH (AXIS_TDATA_WIDTH)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_valid_i (rd_valid_q),
        .s_data_i  (bram_porta_rddata),
        .m_ready_i (m_axis.tready),
        .m_valid_o (w_valid),
        .m_data_o  (w_data),
        .count_o   (w_occ)
    );

    assign m_axis.tvalid = w_valid;
    assign m_axis.tdata  = w_data;
    assign m_axis.tlast  = w_valid && w_last_beat;

    assign w_pop       = w_valid && m_axis.tready;
    assign w_last_beat = (count_q + 1'b1 == len_q);
    assign w_done      = (state_q == ST_DRAIN) && w_pop && w_last_beat;

    // Beats already committed to the buffer, counting this cycle's handshake
    assign w_outstanding = {1'b0, w_occ}
                         + (SKID_CNT_W + 1)'(req_q)
                         + (SKID_CNT_W + 1)'(rd_valid_q)
                         - (SKID_CNT_W + 1)'(w_pop);
    assign w_issue_ok    = may_issue(w_outstanding);

    // A readout starts from idle on request, or straight after the final beat
    // when re-arming; a zero length never starts anything.
    assign w_launch = (cfg_length != '0)
                   && (((state_q == ST_IDLE) && start) || (c_continuous && w_done));

    // Readout controller: latches the configuration, issues one BRAM read per
    // free buffer slot, and tracks accepted beats.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            count_q    <= '0;
            req_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= req_q;
            req_q      <= 1'b0;
            if (w_pop) begin
                count_q <= count_q + 1'b1;
            end

            if (w_launch) begin
                // First read goes out on the launch edge itself
                state_q  <= (cfg_length == c_len_one) ? ST_DRAIN : ST_READ;
                busy_q   <= 1'b1;
                len_q    <= cfg_length;
                addr_q   <= cfg_start;
                issued_q <= c_len_one;
                count_q  <= '0;
                req_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                    end
                    ST_READ: begin
                        if (w_issue_ok) begin
                            addr_q   <= addr_q + 1'b1;
                            issued_q <= issued_q + 1'b1;
                            req_q    <= 1'b1;
                            if (issued_q + 1'b1 == len_q) begin
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_done) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_circular_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_circular_reader
// Description : Self-checking bench for axis_circular_reader (one-shot and
//               continuous instances, 16-word BRAM holding word i = i).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_circular_reader;

    localparam int AW = 4;
    localparam int DW = 32;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- one-shot instance ----------------
    logic [AW-1:0] cfg_start   = '0;
    logic [AW:0]   cfg_length  = '0;
    logic          start       = 1'b0;
    logic          sts_busy;
    logic [AW:0]   sts_count;
    logic          bram_clk;
    logic          bram_rst;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rddata = '0;
    logic          rnd_rdy     = 1'b1;
    logic          rand_en     = 1'b0;

    axis_circular_reader_if #(.DATA_WIDTH(DW)) axs ();
    assign axs.tready = rand_en ? rnd_rdy : 1'b1;
    always @(posedge aclk) rnd_rdy <= 1'($urandom_range(0, 1));
    always @(posedge aclk) bram_rddata <= DW'(bram_addr);

    axis_circular_reader #(
        .AXIS_TDATA_WIDTH (DW),
        .BRAM_ADDR_WIDTH  (AW),
        .CONTINUOUS       ("FALSE")
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_start         (cfg_start),
        .cfg_length        (cfg_length),
        .start             (start),
        .sts_busy          (sts_busy),
        .sts_count         (sts_count),
        .bram_porta_clk    (bram_clk),
        .bram_porta_rst    (bram_rst),
        .bram_porta_addr   (bram_addr),
        .bram_porta_rddata (bram_rddata),
        .m_axis            (axs.master)
    );

    // ---------------- continuous instance ----------------
    logic [AW-1:0] cfg_start_c   = '0;
    logic [AW:0]   cfg_length_c  = '0;
    logic          start_c       = 1'b0;
    logic          busy_c;
    logic [AW:0]   count_c;
    logic          bram_clk_c;
    logic          bram_rst_c;
    logic [AW-1:0] bram_addr_c;
    logic [DW-1:0] bram_rddata_c = '0;

    axis_circular_reader_if #(.DATA_WIDTH(DW)) axc ();
    assign axc.tready = 1'b1;
    always @(posedge aclk) bram_rddata_c <= DW'(bram_addr_c);

    axis_circular_reader #(
        .AXIS_TDATA_WIDTH (DW),
        .BRAM_ADDR_WIDTH  (AW),
        .CONTINUOUS       ("TRUE")
    ) dut_c (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_start         (cfg_start_c),
        .cfg_length        (cfg_length_c),
        .start             (start_c),
        .sts_busy          (busy_c),
        .sts_count         (count_c),
        .bram_porta_clk    (bram_clk_c),
        .bram_porta_rst    (bram_rst_c),
        .bram_porta_addr   (bram_addr_c),
        .bram_porta_rddata (bram_rddata_c),
        .m_axis            (axc.master)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int   exp_data[$];
    bit   exp_last[$];
    int   exp_count  = 0;
    bit   exp_busy   = 1'b0;
    bit   chk_en     = 1'b0;
    int   beat_data[$];
    int   beat_cyc[$];
    bit   beat_last[$];
    int   launch_cyc = 0;
    int   fall_cyc   = -1;
    logic busy_prev  = 1'b0;
    bit   stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int   c_beats    = 0;
    bit   c_en       = 1'b0;

    // Compare one-shot instance against the expected beat queue each cycle
    always @(negedge aclk) begin
        if (chk_en && aresetn) begin
            check("sts_busy", sts_busy, exp_busy);
            check("sts_count", sts_count, exp_count);
            if (busy_prev && !sts_busy) fall_cyc = cyc;
            busy_prev = sts_busy;
            if (stall_prev) begin
                check("stall_hold_valid", axs.tvalid, 1);
                check("stall_hold_data", axs.tdata, stall_data);
            end
            stall_prev = axs.tvalid && !axs.tready;
            stall_data = axs.tdata;
            if (axs.tvalid) begin
                check("beat_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    check("tdata", axs.tdata, exp_data[0]);
                    check("tlast", axs.tlast, exp_last[0]);
                    if (axs.tready) begin
                        beat_data.push_back(int'(axs.tdata));
                        beat_cyc.push_back(cyc);
                        beat_last.push_back(axs.tlast);
                        exp_count++;
                        if (exp_last[0]) exp_busy = 1'b0;
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                    end
                end
            end else begin
                check("tlast_without_tvalid", axs.tlast, 0);
            end
        end
    end

    // Continuous instance: packets of 4 from address 10, tlast every 4th beat
    always @(negedge aclk) begin
        if (chk_en && aresetn) begin
            if (!c_en) begin
                check("c_idle_tvalid", axc.tvalid, 0);
            end else begin
                check("c_busy", busy_c, 1);
                check("c_count_range", count_c <= 5'd4, 1);
                if (axc.tvalid && axc.tready) begin
                    check("c_tdata", axc.tdata, (10 + c_beats % 4) % 16);
                    check("c_tlast", axc.tlast, (c_beats % 4) == 3);
                    c_beats++;
                end
            end
        end
    end

    task automatic launch(input int s, input int len);
        cfg_start  = AW'(s);
        cfg_length = (AW + 1)'(len);
        start      = 1'b1;
        @(posedge aclk); #1;
        start      = 1'b0;
        launch_cyc = cyc;
        exp_count  = 0;
        exp_busy   = 1'b1;
        fall_cyc   = -1;
        beat_data.delete();
        beat_cyc.delete();
        beat_last.delete();
        for (int i = 0; i < len; i++) begin
            exp_data.push_back((s + i) % 16);
            exp_last.push_back(i == len - 1);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_data.size() != 0 && n < limit) begin
            @(posedge aclk);
            n++;
        end
        check("drain_timeout", exp_data.size(), 0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    int t1_lit[8] = '{12, 13, 14, 15, 0, 1, 2, 3};

    initial begin
        int n;
        int prev_beats;

        // Reset values while aresetn is low
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", axs.tvalid, 0);
        check("rst_tlast", axs.tlast, 0);
        check("rst_busy", sts_busy, 0);
        check("rst_count", sts_count, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_bram_rst", bram_rst, 1);
        check("rst_bram_rst_c", bram_rst_c, 1);
        check("bram_clk_low", bram_clk, 0);
        check("bram_clk_c_low", bram_clk_c, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        chk_en  = 1'b1;
        repeat (2) @(posedge aclk); #1;
        check("bram_rst_released", bram_rst, 0);

        // T1: wrap from 12, length 8, tready high
        launch(12, 8);
        wait_drain(100);
        check("t1_beats", beat_data.size(), 8);
        if (beat_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t1_tdata_lit", beat_data[i], t1_lit[i]);
                check("t1_consecutive", beat_cyc[i] - beat_cyc[0], i);
            end
            check("t1_first_latency", beat_cyc[0] - (launch_cyc - 1), 2);
            check("t1_tlast_on_3", beat_last[7] && beat_data[7] == 3, 1);
        end

        // T2: whole buffer from 5
        launch(5, 16);
        wait_drain(100);
        check("t2_beats", beat_data.size(), 16);
        if (beat_data.size() == 16) begin
            check("t2_first", beat_data[0], 5);
            check("t2_top", beat_data[10], 15);
            check("t2_wrap", beat_data[11], 0);
            check("t2_last_addr", beat_data[15], 4);
            check("t2_tlast", beat_last[15], 1);
            check("t2_busy_fall", fall_cyc - beat_cyc[15], 1);
        end
        check("t2_count", sts_count, 16);
        check("t2_busy_after", sts_busy, 0);

        // T3: random backpressure, length 10
        rand_en = 1'b1;
        launch(9, 10);
        wait_drain(400);
        rand_en = 1'b0;
        check("t3_beats", beat_data.size(), 10);
        if (beat_data.size() == 10) begin
            check("t3_beat6", beat_data[6], 15);
            check("t3_beat7", beat_data[7], 0);
            check("t3_tlast", beat_last[9] && beat_data[9] == 2, 1);
        end
        check("t3_count", sts_count, 10);

        // T4: start and cfg changes mid-readout are ignored
        launch(2, 6);
        repeat (2) @(posedge aclk); #1;
        cfg_start  = 4'd7;
        cfg_length = 5'd3;
        start      = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        wait_drain(100);
        check("t4_beats", beat_data.size(), 6);
        if (beat_data.size() == 6) begin
            check("t4_first", beat_data[0], 2);
            check("t4_last", beat_data[5], 7);
        end
        // zero length request is ignored
        prev_beats = beat_data.size();
        cfg_start  = 4'd3;
        cfg_length = '0;
        start      = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (4) @(posedge aclk); #1;
        check("t4_zero_len_busy", sts_busy, 0);
        check("t4_zero_len_nobeats", beat_data.size(), prev_beats);

        // T5: reset after beat 3 of 8
        launch(0, 8);
        n = 0;
        while (beat_data.size() < 3 && n < 50) begin
            @(posedge aclk);
            n++;
        end
        check("t5_reach_beat3", beat_data.size(), 3);
        #1;
        aresetn = 1'b0;
        exp_data.delete();
        exp_last.delete();
        exp_count  = 0;
        exp_busy   = 1'b0;
        stall_prev = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("t5_tvalid_after_rst", axs.tvalid, 0);
        check("t5_count_after_rst", sts_count, 0);
        repeat (20) @(posedge aclk); #1;
        check("t5_no_more_beats", beat_data.size(), 3);

        // T6: continuous re-arming, packets of 4 from address 10
        cfg_start_c  = 4'd10;
        cfg_length_c = 5'd4;
        start_c      = 1'b1;
        @(posedge aclk); #1;
        start_c = 1'b0;
        c_en    = 1'b1;
        repeat (40) @(posedge aclk); #1;
        check("t6_enough_beats", c_beats >= 12, 1);
        check("t6_busy_held", busy_c, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
